// File: rtl/button_boot_ctrl.sv
// Button/boot controller: debounced PCB buttons on a small bus slot, plus a
// warm-boot request path driven by bus writes or a long press of the boot button.

module button_debounce #(
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic clk_24m,
  input  logic rst,
  input  logic pad,
  output logic pressed
);

  logic                      pad_q;
  logic                      sync_1;
  logic                      sync_2;
  logic [DEBOUNCE_WIDTH-1:0] deb_cnt;
  logic                      deb_state;

  // Pad-side flops reset to 1 (released) so nothing looks pressed out of reset.
  // The counter only runs while the synced level disagrees with the debounced
  // state; any sample that agrees restarts the stability window.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      pad_q     <= 1'b1;
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      deb_cnt   <= '0;
      deb_state <= 1'b0;
    end else begin
      pad_q  <= pad;
      sync_1 <= pad_q;
      sync_2 <= sync_1;
      if (~sync_2 == deb_state) begin
        deb_cnt <= '0;
      end else if (deb_cnt == {DEBOUNCE_WIDTH{1'b1}}) begin
        deb_cnt   <= '0;
        deb_state <= ~sync_2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign pressed = deb_state;

endmodule

module button_boot_ctrl #(
  parameter int TIMER_WIDTH    = 24,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic        btn_pad,
  input  logic [2:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  input  logic        wb_we,
  input  logic        wb_cyc_btn,
  input  logic        wb_cyc_boot,
  output logic [31:0] wb_rdata_btn,
  output logic        wb_ack_btn,
  output logic [31:0] wb_rdata_boot,
  output logic        wb_ack_boot,
  output logic        warmboot_req,
  output logic [1:0]  warmboot_sel,
  output logic        btn_val,
  output logic        rst_req
);

  logic                   btn_a_deb;
  logic                   btn_b_deb;
  logic                   btn_pad_deb;
  logic [TIMER_WIDTH-1:0] press_cnt;
  logic                   long_hit;
  logic                   boot_now;
  logic [1:0]             boot_sel;
  logic                   boot_wr;
  logic                   boot_now_nxt;
  logic [1:0]             boot_sel_nxt;
  logic                   unused_wdata;

  button_debounce #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_deb_a (
    .clk_24m (clk_24m),
    .rst     (rst),
    .pad     (btn_a),
    .pressed (btn_a_deb)
  );

  button_debounce #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_deb_b (
    .clk_24m (clk_24m),
    .rst     (rst),
    .pad     (btn_b),
    .pressed (btn_b_deb)
  );

  button_debounce #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_deb_pad (
    .clk_24m (clk_24m),
    .rst     (rst),
    .pad     (btn_pad),
    .pressed (btn_pad_deb)
  );

  assign btn_val = btn_pad_deb;

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      wb_ack_btn   <= 1'b0;
      wb_rdata_btn <= '0;
    end else begin
      wb_ack_btn   <= wb_cyc_btn & ~wb_ack_btn;
      wb_rdata_btn <= (wb_cyc_btn & ~wb_we & ~wb_ack_btn) ?
                      {30'b0, btn_b_deb, btn_a_deb} : 32'b0;
    end
  end

  assign wb_ack_boot   = wb_cyc_boot;
  assign wb_rdata_boot = '0;

  assign boot_wr      = wb_cyc_boot & wb_we & (wb_addr == 3'd0);
  assign boot_now_nxt = boot_wr ? wb_wdata[2]   : boot_now;
  assign boot_sel_nxt = boot_wr ? wb_wdata[1:0] : boot_sel;
  assign unused_wdata = ^wb_wdata[31:3];

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      boot_now <= 1'b0;
      boot_sel <= 2'b00;
    end else begin
      boot_now <= boot_now_nxt;
      boot_sel <= boot_sel_nxt;
    end
  end

  // Short press releases with a nonzero count give one rst_req cycle; the
  // counter clears on that same edge, which keeps the pulse one cycle wide.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      press_cnt <= '0;
      long_hit  <= 1'b0;
      rst_req   <= 1'b0;
    end else begin
      rst_req <= ~btn_val & (press_cnt != '0) & ~long_hit;
      if (!btn_val) begin
        press_cnt <= '0;
      end else if (press_cnt != {TIMER_WIDTH{1'b1}}) begin
        press_cnt <= press_cnt + 1'b1;
      end
      if (press_cnt == {TIMER_WIDTH{1'b1}}) begin
        long_hit <= 1'b1;
      end
    end
  end

  // Selection follows the pending choice until the request fires, then freezes.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      warmboot_req <= 1'b0;
      warmboot_sel <= 2'b00;
    end else if (!warmboot_req) begin
      warmboot_req <= long_hit | boot_now_nxt;
      warmboot_sel <= long_hit ? 2'b01 : boot_sel_nxt;
    end
  end

endmodule

// File: tb/tb_button_boot_ctrl.sv
// Directed bench for button_boot_ctrl with short debounce/long-press widths.

module tb_button_boot_ctrl;

  localparam int DW = 4;
  localparam int TW = 6;

  logic        clk_24m = 1'b0;
  logic        rst;
  logic        btn_a, btn_b, btn_pad;
  logic [2:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we, wb_cyc_btn, wb_cyc_boot;
  logic [31:0] wb_rdata_btn, wb_rdata_boot;
  logic        wb_ack_btn, wb_ack_boot;
  logic        warmboot_req;
  logic [1:0]  warmboot_sel;
  logic        btn_val, rst_req;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;
  int first_idx;
  logic [31:0] rd;
  logic        ak;

  always #5 clk_24m = ~clk_24m;

  button_boot_ctrl #(.TIMER_WIDTH(TW), .DEBOUNCE_WIDTH(DW)) dut (
    .clk_24m       (clk_24m),
    .rst           (rst),
    .btn_a         (btn_a),
    .btn_b         (btn_b),
    .btn_pad       (btn_pad),
    .wb_addr       (wb_addr),
    .wb_wdata      (wb_wdata),
    .wb_we         (wb_we),
    .wb_cyc_btn    (wb_cyc_btn),
    .wb_cyc_boot   (wb_cyc_boot),
    .wb_rdata_btn  (wb_rdata_btn),
    .wb_ack_btn    (wb_ack_btn),
    .wb_rdata_boot (wb_rdata_boot),
    .wb_ack_boot   (wb_ack_boot),
    .warmboot_req  (warmboot_req),
    .warmboot_sel  (warmboot_sel),
    .btn_val       (btn_val),
    .rst_req       (rst_req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_24m);
  endtask

  task automatic bus_read(output logic [31:0] d, output logic a);
    wb_cyc_btn = 1'b1;
    wb_we      = 1'b0;
    @(negedge clk_24m);
    d = wb_rdata_btn;
    a = wb_ack_btn;
    wb_cyc_btn = 1'b0;
    @(negedge clk_24m);
  endtask

  initial begin
    rst = 1'b1; btn_a = 1'b1; btn_b = 1'b1; btn_pad = 1'b1;
    wb_addr = 3'd0; wb_wdata = 32'd0; wb_we = 1'b0;
    wb_cyc_btn = 1'b0; wb_cyc_boot = 1'b0;
    cyc(3);
    check("rst_ack_btn",   32'(wb_ack_btn), 32'd0);
    check("rst_rdata_btn", wb_rdata_btn, 32'd0);
    check("rst_req",       32'(warmboot_req), 32'd0);
    check("rst_sel",       32'(warmboot_sel), 32'd0);
    check("rst_btn_val",   32'(btn_val), 32'd0);
    check("rst_rst_req",   32'(rst_req), 32'd0);
    check("rst_ack_boot",  32'(wb_ack_boot), 32'd0);
    check("rdata_boot",    wb_rdata_boot, 32'd0);
    rst = 1'b0;
    cyc(2);
    check("no_false_press", 32'(btn_val), 32'd0);

    // button A pressed, read it back
    btn_a = 1'b0;
    cyc(30);
    wb_cyc_btn = 1'b1; wb_we = 1'b0;
    #1 check("ack_not_comb", 32'(wb_ack_btn), 32'd0);
    cyc(1);
    check("a_ack",   32'(wb_ack_btn), 32'd1);
    check("a_rdata", wb_rdata_btn, 32'h1);
    cyc(1);
    check("a_ack_one_cycle", 32'(wb_ack_btn), 32'd0);
    check("a_rdata_cleared", wb_rdata_btn, 32'd0);
    wb_cyc_btn = 1'b0;
    cyc(1);
    wb_cyc_btn = 1'b1; wb_we = 1'b1; wb_wdata = 32'hFFFF_FFFF;
    cyc(1);
    check("btn_wr_ack",   32'(wb_ack_btn), 32'd1);
    check("btn_wr_rdata", wb_rdata_btn, 32'd0);
    wb_cyc_btn = 1'b0; wb_we = 1'b0;
    cyc(1);
    check("btn_wr_ack_drop", 32'(wb_ack_btn), 32'd0);
    btn_a = 1'b1;
    cyc(25);

    // button B bouncing never settles
    for (int i = 0; i < 40; i++) begin
      btn_b = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    bus_read(rd, ak);
    check("b_bounce_ack",   32'(ak), 32'd1);
    check("b_bounce_rdata", rd, 32'd0);
    btn_b = 1'b0;
    cyc(25);
    bus_read(rd, ak);
    check("b_stable_rdata", rd, 32'h2);
    btn_b = 1'b1;
    cyc(25);

    // boot write to nonzero address is ignored
    wb_cyc_boot = 1'b1; wb_we = 1'b1; wb_addr = 3'd1; wb_wdata = 32'h6;
    #1 check("boot_ack_comb_a1", 32'(wb_ack_boot), 32'd1);
    check("boot_rdata_a1", wb_rdata_boot, 32'd0);
    cyc(1);
    wb_cyc_boot = 1'b0; wb_we = 1'b0; wb_addr = 3'd0;
    #1 check("boot_ack_idle", 32'(wb_ack_boot), 32'd0);
    cyc(2);
    check("a1_no_req", 32'(warmboot_req), 32'd0);

    // boot write at address 0
    wb_cyc_boot = 1'b1; wb_we = 1'b1; wb_addr = 3'd0; wb_wdata = 32'h6;
    #1 check("boot_ack_comb_a0", 32'(wb_ack_boot), 32'd1);
    cyc(1);
    wb_cyc_boot = 1'b0; wb_we = 1'b0;
    check("a0_req", 32'(warmboot_req), 32'd1);
    check("a0_sel", 32'(warmboot_sel), 32'd2);
    wb_cyc_boot = 1'b1; wb_we = 1'b1; wb_wdata = 32'h1;
    cyc(1);
    wb_cyc_boot = 1'b0; wb_we = 1'b0;
    cyc(1);
    check("sel_frozen", 32'(warmboot_sel), 32'd2);

    rst = 1'b1;
    #1 check("async_rst_req", 32'(warmboot_req), 32'd0);
    check("async_rst_sel", 32'(warmboot_sel), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // short press -> one rst_req on release
    pulses = 0; first_idx = -1;
    btn_pad = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (rst_req) pulses++;
      if (i == 18) check("press_deb_edge_before", 32'(btn_val), 32'd0);
      if (i == 19) check("press_deb_edge", 32'(btn_val), 32'd1);
    end
    check("short_no_pulse_held", 32'(pulses), 32'd0);
    btn_pad = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (rst_req) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    check("short_pulse_count", 32'(pulses), 32'd1);
    check("short_pulse_time", 32'(first_idx), 32'd20);
    check("short_no_req", 32'(warmboot_req), 32'd0);
    check("short_released", 32'(btn_val), 32'd0);

    // long press -> warm boot image 1
    pulses = 0;
    btn_pad = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      if (rst_req) pulses++;
      if (i == 83) check("long_req_before", 32'(warmboot_req), 32'd0);
      if (i == 84) check("long_req_edge", 32'(warmboot_req), 32'd1);
    end
    check("long_sel", 32'(warmboot_sel), 32'd1);
    wb_cyc_boot = 1'b1; wb_we = 1'b1; wb_addr = 3'd0; wb_wdata = 32'h6;
    cyc(1);
    wb_cyc_boot = 1'b0; wb_we = 1'b0;
    btn_pad = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (rst_req) pulses++;
    end
    check("long_no_rst_req", 32'(pulses), 32'd0);
    check("long_sel_frozen", 32'(warmboot_sel), 32'd1);

    // reset in the middle of a long press
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    btn_pad = 1'b0;
    cyc(59);
    check("mid_press_active", 32'(btn_val), 32'd1);
    rst = 1'b1;
    #1 check("mid_rst_req",   32'(warmboot_req), 32'd0);
    check("mid_rst_sel",      32'(warmboot_sel), 32'd0);
    check("mid_rst_btn_val",  32'(btn_val), 32'd0);
    check("mid_rst_rst_req",  32'(rst_req), 32'd0);
    check("mid_rst_ack",      32'(wb_ack_btn), 32'd0);
    check("mid_rst_rdata",    wb_rdata_btn, 32'd0);
    cyc(3);
    rst = 1'b0;
    for (int i = 1; i <= 84; i++) begin
      cyc(1);
      if (i == 19) check("re_hold_deb", 32'(btn_val), 32'd1);
      if (i == 83) check("re_hold_req_before", 32'(warmboot_req), 32'd0);
      if (i == 84) check("re_hold_req", 32'(warmboot_req), 32'd1);
    end
    check("re_hold_sel", 32'(warmboot_sel), 32'd1);
    btn_pad = 1'b1;
    cyc(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
